// File: rtl/ysyx_22040386_mem_arbiter.sv
// Shares one memory port between the instruction fetch and load/store requesters.
// One transaction in flight at a time, with a watchdog that aborts stuck transactions.
module ysyx_22040386_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int PRIO_LS = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_ARB_clk,
  input  logic                  i_ARB_rst,
  input  logic                  i_ARB_if_req,
  input  logic [ADDR_W-1:0]     i_ARB_if_addr,
  output logic                  o_ARB_if_gnt,
  output logic                  o_ARB_if_rvalid,
  output logic [DATA_W-1:0]     o_ARB_if_rdata,
  input  logic                  i_ARB_ls_req,
  input  logic                  i_ARB_ls_we,
  input  logic [ADDR_W-1:0]     i_ARB_ls_addr,
  input  logic [DATA_W-1:0]     i_ARB_ls_wdata,
  input  logic [DATA_W/8-1:0]   i_ARB_ls_wmask,
  output logic                  o_ARB_ls_gnt,
  output logic                  o_ARB_ls_rvalid,
  output logic [DATA_W-1:0]     o_ARB_ls_rdata,
  output logic                  o_ARB_mem_valid,
  output logic                  o_ARB_mem_we,
  output logic [ADDR_W-1:0]     o_ARB_mem_addr,
  output logic [DATA_W-1:0]     o_ARB_mem_wdata,
  output logic [DATA_W/8-1:0]   o_ARB_mem_wmask,
  input  logic                  i_ARB_mem_ready,
  input  logic                  i_ARB_mem_rvalid,
  input  logic [DATA_W-1:0]     i_ARB_mem_rdata,
  output logic                  o_ARB_timeout
);

  localparam int   MASK_W = DATA_W / 8;
  localparam int   CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic PRIO   = (PRIO_LS != 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state;
  logic                owner;
  logic                last_owner;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [CNT_W-1:0]    cnt;
  logic                timeout_q;

  logic grant_ls;
  logic grant_if;
  logic in_idle;
  logic abort;
  logic complete;
  logic done;

  // On a tie in round-robin mode the requester that did not go last wins.
  assign grant_ls = i_ARB_ls_req & (~i_ARB_if_req | PRIO | ~last_owner);
  assign grant_if = i_ARB_if_req & ~grant_ls;
  assign in_idle  = (state == IDLE) & ~i_ARB_rst;

  // The watchdog wins over a response arriving in the same cycle.
  assign abort    = (state != IDLE) & (cnt == CNT_W'(TIMEOUT - 1));
  assign complete = (state == RESP) & i_ARB_mem_rvalid & ~abort;
  assign done     = complete | abort;

  assign o_ARB_if_gnt    = in_idle & grant_if;
  assign o_ARB_ls_gnt    = in_idle & grant_ls;
  assign o_ARB_if_rvalid = done & ~owner;
  assign o_ARB_ls_rvalid = done & owner;
  assign o_ARB_if_rdata  = (complete & ~owner) ? i_ARB_mem_rdata : '0;
  assign o_ARB_ls_rdata  = (complete & owner & ~we_q) ? i_ARB_mem_rdata : '0;

  assign o_ARB_mem_valid = (state == REQ);
  assign o_ARB_mem_we    = we_q;
  assign o_ARB_mem_addr  = addr_q;
  assign o_ARB_mem_wdata = wdata_q;
  assign o_ARB_mem_wmask = wmask_q;
  assign o_ARB_timeout   = timeout_q | abort;

  always_ff @(posedge i_ARB_clk or posedge i_ARB_rst) begin
    if (i_ARB_rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt        <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_ARB_if_req | i_ARB_ls_req) begin
            owner      <= grant_ls;
            last_owner <= grant_ls;
            we_q       <= grant_ls & i_ARB_ls_we;
            addr_q     <= grant_ls ? i_ARB_ls_addr : i_ARB_if_addr;
            wdata_q    <= grant_ls ? i_ARB_ls_wdata : '0;
            wmask_q    <= grant_ls ? i_ARB_ls_wmask : '0;
            cnt        <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (abort) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else if (i_ARB_mem_ready) begin
            state <= RESP;
          end
        end
        RESP: begin
          cnt <= cnt + CNT_W'(1);
          if (abort) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else if (i_ARB_mem_rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// Directed bench for the memory arbiter: fixed-priority instance with a short
// watchdog, plus a round-robin instance for the tie-break ordering.
module tb_ysyx_22040386_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // fixed-priority instance
  logic        if_req, ls_req, ls_we, mem_ready, mem_rvalid;
  logic [63:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [7:0]  ls_wmask;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_valid, mem_we, tmo;
  logic [63:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;

  // round-robin instance
  logic        r_if_req, r_ls_req, r_mem_ready, r_mem_rvalid;
  logic        r_if_gnt, r_if_rvalid, r_ls_gnt, r_ls_rvalid, r_mem_valid, r_mem_we, r_tmo;
  logic [63:0] r_if_rdata, r_ls_rdata, r_mem_addr, r_mem_wdata;
  logic [7:0]  r_mem_wmask;

  ysyx_22040386_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .PRIO_LS(1), .TIMEOUT(8)) dut (
    .i_ARB_clk(clk), .i_ARB_rst(rst),
    .i_ARB_if_req(if_req), .i_ARB_if_addr(if_addr),
    .o_ARB_if_gnt(if_gnt), .o_ARB_if_rvalid(if_rvalid), .o_ARB_if_rdata(if_rdata),
    .i_ARB_ls_req(ls_req), .i_ARB_ls_we(ls_we), .i_ARB_ls_addr(ls_addr),
    .i_ARB_ls_wdata(ls_wdata), .i_ARB_ls_wmask(ls_wmask),
    .o_ARB_ls_gnt(ls_gnt), .o_ARB_ls_rvalid(ls_rvalid), .o_ARB_ls_rdata(ls_rdata),
    .o_ARB_mem_valid(mem_valid), .o_ARB_mem_we(mem_we), .o_ARB_mem_addr(mem_addr),
    .o_ARB_mem_wdata(mem_wdata), .o_ARB_mem_wmask(mem_wmask),
    .i_ARB_mem_ready(mem_ready), .i_ARB_mem_rvalid(mem_rvalid), .i_ARB_mem_rdata(mem_rdata),
    .o_ARB_timeout(tmo)
  );

  ysyx_22040386_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .PRIO_LS(0), .TIMEOUT(8)) dut_rr (
    .i_ARB_clk(clk), .i_ARB_rst(rst),
    .i_ARB_if_req(r_if_req), .i_ARB_if_addr(64'h8000_0000),
    .o_ARB_if_gnt(r_if_gnt), .o_ARB_if_rvalid(r_if_rvalid), .o_ARB_if_rdata(r_if_rdata),
    .i_ARB_ls_req(r_ls_req), .i_ARB_ls_we(1'b0), .i_ARB_ls_addr(64'h8000_2000),
    .i_ARB_ls_wdata(64'h0), .i_ARB_ls_wmask(8'h00),
    .o_ARB_ls_gnt(r_ls_gnt), .o_ARB_ls_rvalid(r_ls_rvalid), .o_ARB_ls_rdata(r_ls_rdata),
    .o_ARB_mem_valid(r_mem_valid), .o_ARB_mem_we(r_mem_we), .o_ARB_mem_addr(r_mem_addr),
    .o_ARB_mem_wdata(r_mem_wdata), .o_ARB_mem_wmask(r_mem_wmask),
    .i_ARB_mem_ready(r_mem_ready), .i_ARB_mem_rvalid(r_mem_rvalid), .i_ARB_mem_rdata(64'h0),
    .o_ARB_timeout(r_tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    if_req = 1'b1; if_addr = 64'h0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h0;
    ls_wdata = 64'h0; ls_wmask = 8'h00; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'h0;
    r_if_req = 1'b0; r_ls_req = 1'b0; r_mem_ready = 1'b0; r_mem_rvalid = 1'b0;

    // reset: outputs low even with requests pending
    #2;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_timeout", tmo, 0);
    tick;
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    settle;

    // IF read, minimum latency
    if_req = 1'b1; if_addr = 64'h8000_0000;
    settle;
    chk("if_gnt_c0", if_gnt, 1);
    chk("ls_gnt_c0", ls_gnt, 0);
    tick;
    if_req = 1'b0; if_addr = 64'h0; mem_ready = 1'b1;
    settle;
    chk("if_mem_valid_c1", mem_valid, 1);
    chk("if_mem_addr_c1", mem_addr, 64'h8000_0000);
    chk("if_mem_we_c1", mem_we, 0);
    tick;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0013_0000_0413;
    settle;
    chk("if_rvalid_c2", if_rvalid, 1);
    chk("if_rdata_c2", if_rdata, 64'h0000_0013_0000_0413);
    chk("if_ls_rvalid_c2", ls_rvalid, 0);
    chk("if_mem_valid_c2", mem_valid, 0);
    tick;
    mem_rvalid = 1'b0;
    settle;
    chk("if_rvalid_c3", if_rvalid, 0);
    chk("if_rdata_c3", if_rdata, 0);

    // simultaneous requests, LS has priority
    if_req = 1'b1; if_addr = 64'h8000_0100;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_1000; ls_wdata = 64'hFF; ls_wmask = 8'h01;
    settle;
    chk("pri_ls_gnt", ls_gnt, 1);
    chk("pri_if_gnt", if_gnt, 0);
    tick;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 64'h0; ls_wdata = 64'h0; ls_wmask = 8'h00;
    mem_ready = 1'b1;
    settle;
    chk("pri_mem_we", mem_we, 1);
    chk("pri_mem_addr", mem_addr, 64'h8000_1000);
    chk("pri_mem_wdata", mem_wdata, 64'hFF);
    chk("pri_mem_wmask", mem_wmask, 8'h01);
    chk("pri_if_wait", if_gnt, 0);
    tick;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
    settle;
    chk("pri_ls_rvalid", ls_rvalid, 1);
    chk("pri_ls_rdata_wr", ls_rdata, 0);
    chk("pri_if_rvalid", if_rvalid, 0);
    chk("pri_if_wait2", if_gnt, 0);
    tick;
    mem_rvalid = 1'b0;
    settle;
    chk("pri_if_gnt_after", if_gnt, 1);
    tick;
    if_req = 1'b0; mem_ready = 1'b1;
    settle;
    chk("pri_if_mem_addr", mem_addr, 64'h8000_0100);
    chk("pri_if_mem_we", mem_we, 0);
    chk("pri_if_mem_wmask", mem_wmask, 8'h00);
    tick;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
    settle;
    chk("pri_if_rvalid2", if_rvalid, 1);
    chk("pri_if_rdata2", if_rdata, 64'h1122_3344_5566_7788);
    tick;
    mem_rvalid = 1'b0;

    // stall: ready low for 5 cycles while IF keeps requesting
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_2000; ls_wdata = 64'hA5A5; ls_wmask = 8'hFF;
    if_req = 1'b1; if_addr = 64'h8000_0200;
    settle;
    chk("stl_ls_gnt", ls_gnt, 1);
    tick;
    ls_req = 1'b0; ls_addr = 64'h0; ls_wdata = 64'h0;
    for (int i = 0; i < 5; i++) begin
      settle;
      chk("stl_mem_valid", mem_valid, 1);
      chk("stl_mem_addr", mem_addr, 64'h8000_2000);
      chk("stl_mem_wdata", mem_wdata, 64'hA5A5);
      chk("stl_no_gnt", if_gnt, 0);
      tick;
    end
    mem_ready = 1'b1;
    settle;
    chk("stl_accept_valid", mem_valid, 1);
    tick;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1;
    settle;
    chk("stl_ls_rvalid", ls_rvalid, 1);
    chk("stl_no_timeout", tmo, 0);
    tick;
    mem_rvalid = 1'b0;
    settle;
    chk("stl_if_gnt", if_gnt, 1);
    tick;
    if_req = 1'b0; mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h77;
    settle;
    chk("stl_if_rvalid", if_rvalid, 1);
    chk("stl_if_rdata", if_rdata, 64'h77);
    tick;
    mem_rvalid = 1'b0;

    // watchdog: accepted but never answered; abort on 8th cycle in REQ/RESP
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_3000;
    settle;
    chk("wd_ls_gnt", ls_gnt, 1);
    tick;
    ls_req = 1'b0; mem_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      settle;
      chk("wd_no_rvalid", ls_rvalid, 0);
      chk("wd_no_timeout", tmo, 0);
      tick;
      mem_ready = 1'b0;
    end
    mem_rvalid = 1'b1; mem_rdata = 64'hBEEF;
    settle;
    chk("wd_timeout", tmo, 1);
    chk("wd_ls_rvalid", ls_rvalid, 1);
    chk("wd_ls_rdata", ls_rdata, 0);
    chk("wd_if_rvalid", if_rvalid, 0);
    tick;
    mem_rvalid = 1'b0;
    settle;
    chk("wd_rvalid_after", ls_rvalid, 0);
    chk("wd_sticky", tmo, 1);
    if_req = 1'b1; if_addr = 64'h8000_0300;
    settle;
    chk("wd_new_gnt", if_gnt, 1);
    tick;
    if_req = 1'b0; mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h42;
    settle;
    chk("wd_new_rvalid", if_rvalid, 1);
    chk("wd_new_rdata", if_rdata, 64'h42);
    chk("wd_sticky2", tmo, 1);
    tick;
    mem_rvalid = 1'b0;

    // reset in RESP
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_4000;
    settle;
    chk("rm_ls_gnt", ls_gnt, 1);
    tick;
    ls_req = 1'b0; mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    settle;
    rst = 1'b1; if_req = 1'b1; if_addr = 64'h8000_0400; mem_rvalid = 1'b1; mem_rdata = 64'h99;
    settle;
    chk("rm_ls_rvalid", ls_rvalid, 0);
    chk("rm_ls_rdata", ls_rdata, 0);
    chk("rm_if_gnt", if_gnt, 0);
    chk("rm_timeout", tmo, 0);
    chk("rm_mem_valid", mem_valid, 0);
    chk("rm_mem_addr", mem_addr, 0);
    if_req = 1'b0;
    tick;
    rst = 1'b0;
    settle;
    chk("rm_post_rvalid", ls_rvalid, 0);
    chk("rm_post_if_rvalid", if_rvalid, 0);
    mem_rvalid = 1'b0; if_req = 1'b1;
    settle;
    chk("rm_post_gnt", if_gnt, 1);
    tick;
    if_req = 1'b0; mem_ready = 1'b1;
    settle;
    chk("rm_post_valid", mem_valid, 1);
    chk("rm_post_addr", mem_addr, 64'h8000_0400);
    tick;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5;
    settle;
    chk("rm_post_if_rvalid2", if_rvalid, 1);
    tick;
    mem_rvalid = 1'b0;

    // round-robin: last_owner starts as LS, so IF takes the first tie
    r_if_req = 1'b1; r_ls_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic exp_ls;
      exp_ls = (t % 2) == 1;
      settle;
      chk("rr_if_gnt", r_if_gnt, !exp_ls);
      chk("rr_ls_gnt", r_ls_gnt, exp_ls);
      tick;
      r_mem_ready = 1'b1;
      tick;
      r_mem_ready = 1'b0; r_mem_rvalid = 1'b1;
      settle;
      chk("rr_if_rvalid", r_if_rvalid, !exp_ls);
      chk("rr_ls_rvalid", r_ls_rvalid, exp_ls);
      tick;
      r_mem_rvalid = 1'b0;
    end
    r_if_req = 1'b0; r_ls_req = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
